// File: rtl/fpn_round_pipe.sv
`default_nettype none
// ============================================================================
// fpn_round_pipe : two-stage rounding/packing unit with valid/ready handshake
// Rev 1.0
// ============================================================================
module fpn_round_pipe #(
    parameter int FPWID = 64,
    parameter int TAGW  = 4,
    localparam int EMSB = (FPWID == 16) ? 4 : (FPWID == 32) ? 7 : (FPWID == 64) ? 10 : 14,
    localparam int FMSB = FPWID - EMSB - 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             i_sign,
    input  logic [EMSB:0]    i_exp,
    input  logic [FMSB+3:0]  i_sig,
    input  logic [2:0]       i_rm,
    input  logic [TAGW-1:0]  i_tag,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [FPWID-1:0] o_res,
    output logic [TAGW-1:0]  o_tag,
    output logic             o_inexact,
    output logic             o_overflow,
    output logic             o_underflow
);
    localparam int         SUMW   = EMSB + FMSB + 2;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic             s1_valid_q,   s1_valid_d;
    logic             s1_sign_q,    s1_sign_d;
    logic [EMSB:0]    s1_exp_q,     s1_exp_d;
    logic [FMSB:0]    s1_frac_q,    s1_frac_d;
    logic             s1_inc_q,     s1_inc_d;
    logic             s1_inexact_q, s1_inexact_d;
    logic             s1_special_q, s1_special_d;
    logic [TAGW-1:0]  s1_tag_q,     s1_tag_d;
    logic             out_valid_q,  out_valid_d;
    logic [FPWID-1:0] out_res_q,    out_res_d;
    logic [TAGW-1:0]  out_tag_q,    out_tag_d;
    logic             out_inex_q,   out_inex_d;
    logic             out_ovf_q,    out_ovf_d;
    logic             out_unf_q,    out_unf_d;

    logic             s1_adv;
    logic             lsb, grd, stk, inc;
    logic [SUMW-1:0]  sum;
    logic [EMSB:0]    rnd_exp;
    logic [FMSB:0]    rnd_frac;
    logic [FPWID-1:0] s2_res;
    logic             s2_inex, s2_ovf, s2_unf;

    // The normaliser guarantees the hidden bit; it never reaches the packed result.
    logic             unused_hidden;
    assign unused_hidden = i_sig[FMSB+3];

    assign s1_adv  = s1_valid_q & (~out_valid_q | o_ready);
    assign i_ready = ~s1_valid_q | s1_adv;

    always_comb begin
        lsb = i_sig[2];
        grd = i_sig[1];
        stk = i_sig[0];
        case (i_rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = i_sign & (grd | stk);
            RM_RUP:  inc = ~i_sign & (grd | stk);
            RM_RMM:  inc = grd;
            default: inc = grd & (stk | lsb);
        endcase
    end

    always_comb begin
        sum                 = {s1_exp_q, s1_frac_q} + {{(SUMW-1){1'b0}}, s1_inc_q};
        {rnd_exp, rnd_frac} = sum;
        s2_res  = {s1_sign_q, rnd_exp, rnd_frac};
        s2_inex = s1_inexact_q;
        s2_ovf  = &rnd_exp;
        s2_unf  = (rnd_exp == '0) & s1_inexact_q;
        if (s1_special_q) begin
            // Inf passes through; any NaN leaves quiet with its payload intact.
            s2_inex = 1'b0;
            s2_ovf  = 1'b0;
            s2_unf  = 1'b0;
            if (s1_frac_q == '0) begin
                s2_res = {s1_sign_q, s1_exp_q, s1_frac_q};
            end else begin
                s2_res = {s1_sign_q, s1_exp_q, 1'b1, s1_frac_q[FMSB-1:0]};
            end
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_exp_d     = s1_exp_q;
        s1_frac_d    = s1_frac_q;
        s1_inc_d     = s1_inc_q;
        s1_inexact_d = s1_inexact_q;
        s1_special_d = s1_special_q;
        s1_tag_d     = s1_tag_q;
        out_valid_d  = out_valid_q;
        out_res_d    = out_res_q;
        out_tag_d    = out_tag_q;
        out_inex_d   = out_inex_q;
        out_ovf_d    = out_ovf_q;
        out_unf_d    = out_unf_q;

        if (i_ready) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_sign_d    = i_sign;
                s1_exp_d     = i_exp;
                s1_frac_d    = i_sig[FMSB+2:2];
                s1_inc_d     = inc;
                s1_inexact_d = grd | stk;
                s1_special_d = &i_exp;
                s1_tag_d     = i_tag;
            end
        end

        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_res_d   = s2_res;
            out_tag_d   = s1_tag_q;
            out_inex_d  = s2_inex;
            out_ovf_d   = s2_ovf;
            out_unf_d   = s2_unf;
        end else if (o_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_frac_q    <= '0;
            s1_inc_q     <= 1'b0;
            s1_inexact_q <= 1'b0;
            s1_special_q <= 1'b0;
            s1_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_res_q    <= '0;
            out_tag_q    <= '0;
            out_inex_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_unf_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_frac_q    <= s1_frac_d;
            s1_inc_q     <= s1_inc_d;
            s1_inexact_q <= s1_inexact_d;
            s1_special_q <= s1_special_d;
            s1_tag_q     <= s1_tag_d;
            out_valid_q  <= out_valid_d;
            out_res_q    <= out_res_d;
            out_tag_q    <= out_tag_d;
            out_inex_q   <= out_inex_d;
            out_ovf_q    <= out_ovf_d;
            out_unf_q    <= out_unf_d;
        end
    end

    assign o_valid     = out_valid_q;
    assign o_res       = out_res_q;
    assign o_tag       = out_tag_q;
    assign o_inexact   = out_inex_q;
    assign o_overflow  = out_ovf_q;
    assign o_underflow = out_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fpn_round_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fpn_round_pipe : directed vectors with a queue-based scoreboard, FPWID=64
// Rev 1.0
// ============================================================================
module tb_fpn_round_pipe;
    localparam int FPWID = 64;
    localparam int TAGW  = 4;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  tag;
        logic [2:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic        i_sign = 1'b0;
    logic [10:0] i_exp = '0;
    logic [54:0] i_sig = '0;
    logic [2:0]  i_rm = '0;
    logic [3:0]  i_tag = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [63:0] o_res;
    logic [3:0]  o_tag;
    logic        o_inexact, o_overflow, o_underflow;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    logic [3:0]  tag_ctr = 4'd1;
    logic [51:0] FONES = '1;

    fpn_round_pipe #(.FPWID(FPWID), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_sig(i_sig), .i_rm(i_rm), .i_tag(i_tag),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_res(o_res), .o_tag(o_tag),
        .o_inexact(o_inexact), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = pattern 1,0,0,1 repeating, 2 = stalled.
    initial begin
        int rcnt = 0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                1: begin
                    o_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                    rcnt++;
                end
                2:       o_ready = 1'b0;
                default: o_ready = 1'b1;
            endcase
        end
    end

    // Monitor: samples between edges, after o_ready has settled for the next edge.
    initial begin
        logic        stalled = 1'b0;
        logic [63:0] h_res;
        logic [3:0]  h_tag;
        logic [2:0]  h_flags;
        logic        exp_ir;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                checks++;
                if (!o_valid || o_res !== h_res || o_tag !== h_tag ||
                    {o_inexact, o_overflow, o_underflow} !== h_flags) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b res=%h tag=%h, want valid=1 res=%h tag=%h",
                             o_valid, o_res, o_tag, h_res, h_tag);
                end
            end
            exp_ir = (o_valid && !o_ready) ? (sb.size() < 2) : 1'b1;
            checks++;
            if (i_ready !== exp_ir) begin
                errors++;
                $display("FAIL i_ready: got %b, want %b (o_valid=%b o_ready=%b inflight=%0d)",
                         i_ready, exp_ir, o_valid, o_ready, sb.size());
            end
            if (o_valid && o_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got res=%h tag=%h, want no output", o_res, o_tag);
                end else begin
                    e = sb.pop_front();
                    if (o_res !== e.res || o_tag !== e.tag ||
                        {o_inexact, o_overflow, o_underflow} !== e.flags) begin
                        errors++;
                        $display("FAIL result tag=%0d: got res=%h tag=%h ioU=%b, want res=%h tag=%h ioU=%b",
                                 e.tag, o_res, o_tag, {o_inexact, o_overflow, o_underflow},
                                 e.res, e.tag, e.flags);
                    end
                end
            end
            stalled = o_valid && !o_ready;
            h_res   = o_res;
            h_tag   = o_tag;
            h_flags = {o_inexact, o_overflow, o_underflow};
        end
    end

    task automatic send(input logic sg, input logic [10:0] e, input logic [51:0] f,
                        input logic g, input logic s, input logic [2:0] rm,
                        input logic [63:0] res, input logic [2:0] flags);
        bit   done = 0;
        logic acc;
        exp_t x;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            #1;
            i_valid = 1'b1;
            i_sign  = sg;
            i_exp   = e;
            i_sig   = {e != 11'd0, f, g, s};
            i_rm    = rm;
            i_tag   = tag_ctr;
            acc     = i_ready;
            @(posedge clk);
            if (acc) begin
                x.res   = res;
                x.tag   = tag_ctr;
                x.flags = flags;
                sb.push_back(x);
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no acceptance for tag %0d, want acceptance", tag_ctr);
        end
        tag_ctr++;
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding, want 0", sb.size());
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_res !== 64'd0 || o_tag !== 4'd0 ||
            {o_inexact, o_overflow, o_underflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got valid=%b res=%h tag=%h flags=%b, want all zero",
                     o_valid, o_res, o_tag, {o_inexact, o_overflow, o_underflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, want 1", i_ready);
        end

        // rm: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5 acts as RNE. flags = {inexact, overflow, underflow}
        send(0, 11'h3FF, 52'h0,  0, 0, 3'd0, 64'h3FF0000000000000, 3'b000);
        send(0, 11'h3FF, 52'h1,  1, 0, 3'd0, 64'h3FF0000000000002, 3'b100);
        send(0, 11'h3FF, 52'h1,  1, 0, 3'd1, 64'h3FF0000000000001, 3'b100);
        send(0, 11'h7FE, FONES,  1, 0, 3'd0, 64'h7FF0000000000000, 3'b110);
        send(0, 11'h7FE, FONES,  1, 0, 3'd1, 64'h7FEFFFFFFFFFFFFF, 3'b100);
        send(1, 11'h7FE, FONES,  1, 0, 3'd2, 64'hFFF0000000000000, 3'b110);
        send(0, 11'h000, FONES,  1, 0, 3'd3, 64'h0010000000000000, 3'b100);
        send(0, 11'h000, FONES,  1, 0, 3'd1, 64'h000FFFFFFFFFFFFF, 3'b101);
        send(0, 11'h7FF, 52'h3,  1, 0, 3'd0, 64'h7FF8000000000003, 3'b000);
        send(1, 11'h7FF, 52'h0,  0, 1, 3'd3, 64'hFFF0000000000000, 3'b000);
        send(0, 11'h3FF, 52'h0,  1, 0, 3'd4, 64'h3FF0000000000001, 3'b100);
        send(0, 11'h3FF, 52'h0,  1, 0, 3'd0, 64'h3FF0000000000000, 3'b100);
        send(0, 11'h3FF, 52'h2,  1, 1, 3'd5, 64'h3FF0000000000003, 3'b100);
        send(0, 11'h3FF, 52'h0,  1, 0, 3'd2, 64'h3FF0000000000000, 3'b100);
        send(1, 11'h3FF, 52'h0,  0, 1, 3'd3, 64'hBFF0000000000000, 3'b100);
        send(1, 11'h3FF, 52'h0,  0, 1, 3'd2, 64'hBFF0000000000001, 3'b100);
        idle();
        drain();

        ready_mode = 1;
        for (int k = 0; k < 5; k++) begin
            send(0, 11'h400 + 11'(k), 52'(k), 0, 0, 3'd0,
                 {1'b0, 11'h400 + 11'(k), 52'(k)}, 3'b000);
        end
        idle();
        drain();

        ready_mode = 2;
        repeat (2) @(negedge clk);
        send(0, 11'h3FF, 52'h5, 0, 0, 3'd0, 64'h3FF0000000000005, 3'b000);
        send(0, 11'h3FF, 52'h6, 0, 0, 3'd0, 64'h3FF0000000000006, 3'b000);
        #3;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_res !== 64'd0 || i_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_inflight: got valid=%b res=%h ready=%b, want valid=0 res=0 ready=1",
                     o_valid, o_res, i_ready);
        end
        sb.delete();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(0, 11'h3FF, 52'h7, 1, 1, 3'd1, 64'h3FF0000000000007, 3'b100);
        idle();
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpn_round_pipe.md
Name: fpn_round_pipe

Overview:
- Parametrised two-stage pipelined rounding and packing unit for the FPU.
- Accepts a normaliser-output value (sign, biased exponent, significand with hidden bit and two extra bits) and produces an IEEE-format result of width FPWID.
- Supports five rounding modes, quiets signalling NaNs, and raises inexact, overflow and underflow flags.
- Uses a valid/ready handshake so it can sit between the normaliser and the FPU result bus with backpressure.

Parameters:
- FPWID, 64: total format width; legal values are 16, 32, 64, 128.
- EMSB, derived: exponent MSB; 4, 7, 10, 14 for the four legal widths.
- FMSB, derived: fraction MSB; 9, 22, 51, 111 for the four legal widths.
- TAGW, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input operation present.
- i_ready  out  1  unit can accept an input this cycle.
- i_sign  in  1  sign.
- i_exp  in  EMSB+1  biased exponent.
- i_sig  in  FMSB+4  significand:
  - bit FMSB+3: hidden bit.
  - bits FMSB+2..2: fraction.
  - bit 1: guard.
  - bit 0: sticky (already OR-reduced upstream).
- i_rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; codes 5–7 act as RNE.
- i_tag  in  TAGW  passthrough tag.
- o_valid  out  1  result present.
- o_ready  in  1  downstream accepts the result.
- o_res  out  FPWID  packed result {sign, exp, fraction}.
- o_tag  out  TAGW  tag of the result.
- o_inexact, o_overflow, o_underflow  out  1 each  exception flags, qualified by o_valid.

Behaviour:
- Reset (async, rst_n=0): both stage valids clear; o_valid=0. o_res, o_tag and all flags reset to 0. i_ready is 1 in the first cycle after reset release. An operation in flight when reset asserts is discarded and produces no output.
- Handshake: a transfer occurs when valid&ready are both high on a clock edge.
  - Each stage advances when it is empty or the next stage advances.
  - i_ready = !s1_valid | s1_advance, a combinational path from o_ready.
  - While o_valid=1 and o_ready=0, o_res, o_tag and the flags hold stable.
  - No drops or duplicates under any o_ready pattern.
- Latency: 2 cycles from input accept to o_valid. Throughput is 1 per cycle when o_ready stays high.
- Stage 1 registers the input fields and computes:
  - lsb=i_sig[2], g=i_sig[1], s=i_sig[0].
  - special = (i_exp == all ones).
  - inc:
    - RNE: g&(s|lsb).
    - RTZ: 0.
    - RDN: sign&(g|s).
    - RUP: !sign&(g|s).
    - RMM: g.
- Stage 2, finite input: {exp,frac} = {i_exp, i_sig[FMSB+2:2]} + inc, a single (EMSB+FMSB+2)-bit add.
  - Fraction carry propagates into the exponent, so rounding promotes a denormal to exponent 1.
  - A carry into the all-ones exponent yields infinity with fraction 0.
  - inexact = g|s.
  - overflow = (result exp all ones); overflow implies inexact.
  - underflow = (result exp == 0) & inexact, i.e. tininess is detected after rounding.
- Stage 2, special input (exp all ones):
  - No rounding; all flags 0.
  - A fraction of 0 passes through as ±infinity.
  - A non-zero fraction is a NaN: it is forced quiet by setting fraction MSB=1, keeping sign and the remaining payload bits, so the QNaN diagnostic codes survive.
- The hidden bit i_sig[FMSB+3] is not stored in the result. The upstream normaliser guarantees hidden=1 for exp≠0 and hidden=0 for exp=0; the unit does not check this.
- The output register loads only on a stage-2 transfer into it; the tag travels unmodified.

Test Plan:
- FPWID=64, o_ready=1, input exp=0x3FF, frac=0, g=s=0, RNE -> o_res=0x3FF0000000000000 two cycles later; all flags 0.
- exp=0x3FF, frac=0x0000000000001, g=1, s=0: RNE -> 0x3FF0000000000002 with inexact=1; RTZ -> 0x3FF0000000000001 with inexact=1.
- exp=0x7FE, frac all ones, g=1, sign=0: RNE -> 0x7FF0000000000000 with overflow=1, inexact=1; RTZ -> 0x7FEFFFFFFFFFFFFF with overflow=0, inexact=1; RDN with sign=1 -> 0xFFF0000000000000.
- Denormal: exp=0, frac all ones, g=1, RUP -> 0x0010000000000000 with underflow=0, inexact=1. Same input with RTZ -> 0x000FFFFFFFFFFFFF with underflow=1.
- Signalling NaN: exp=0x7FF, frac=0x0000000000003 -> 0x7FF8000000000003, flags 0.
- Backpressure and reset:
  - Stream 5 tagged ops while o_ready toggles 1,0,0,1,… -> all 5 arrive in order with correct tags; outputs stable while stalled; i_ready falls only when both stages are full and o_ready=0.
  - Assert rst_n=0 with 2 ops in flight -> o_valid=0 immediately; no stale result appears after release.
